dispatch_stage_param: RTL
=========================

// Module: dispatch_stage_param
// PURPOSE
//  Parametrised rename->dispatch stage: one bundle register with lane valids, per-structure credit
//  check (AL/IQ/LQ/SQ) against occupancy counts, and flush/stall handling. Sits between Rename and
//  IQ/AL/LSQ write ports. Adds a DRAIN mode after a load violation: the next bundle waits for an empty AL.
// PARAMETERS
//  DISPATCH_WIDTH  4   lanes per bundle
//  PKT_W           96  bits per lane packet (opaque payload, passed through)
//  AL_SIZE         128 active-list entries;  IQ_SIZE  64 issue-queue entries
//  LQ_SIZE         32  load-queue entries;   SQ_SIZE  32 store-queue entries
//  CNT_W           8   width of occupancy count inputs (must hold SIZE of each structure)
// PORTS
//  clk              in   1                 clock
//  reset            in   1                 synchronous, active-high
//  laneActive_i     in   DISPATCH_WIDTH    lane enable mask; inactive lanes never valid
//  flush_i          in   1                 recover | exception | reconfigure
//  loadViolation_i  in   1                 memory-ordering violation pulse; arms DRAIN
//  renameReady_i    in   1                 rename bundle present
//  renValid_i       in   DISPATCH_WIDTH    per-lane valid of rename bundle
//  renIsLoad_i      in   DISPATCH_WIDTH    lane is a load;  renIsStore_i  in  DISPATCH_WIDTH  lane is a store
//  renPkt_i         in   DISPATCH_WIDTH*PKT_W  lane packets, lane 0 at LSBs
//  alCnt_i,iqCnt_i,lqCnt_i,sqCnt_i  in  CNT_W  current occupancy
//  dispValid_o      out  DISPATCH_WIDTH    lanes written to IQ/AL this cycle (qualified by fire)
//  dispLoad_o,dispStore_o  out DISPATCH_WIDTH  lanes written to LQ / SQ this cycle
//  dispPkt_o        out  DISPATCH_WIDTH*PKT_W  registered packets
//  backEndReady_o   out  1                 bundle fires this cycle
//  stallFrontEnd_o  out  1                 held bundle did not fire; rename must hold
// BEHAVIOUR
//  - Reset: bundle valids 0, state RUN, all outputs 0 (dispPkt_o 0), counters 0.
//  - Bundle reg: valid v[i], isLd/isSt bits, pkt. Loads when !stallFrontEnd_o: v <= renameReady_i ?
//    renValid_i & laneActive_i : 0. Latency rename->dispatch = 1 cycle when no stall.
//  - Need counts (popcount of held bundle): nAl=nIq=popcnt(v); nLq=popcnt(v&isLd); nSq=popcnt(v&isSt).
//  - Credit ok iff alCnt_i+nAl<=AL_SIZE && iqCnt_i+nIq<=IQ_SIZE && lqCnt_i+nLq<=LQ_SIZE &&
//    sqCnt_i+nSq<=SQ_SIZE; sums computed in CNT_W+1 bits (no wrap). Exact-fill (==SIZE) allowed.
//  - fire = |v && credit_ok && !flush_i && (state==RUN || alCnt_i==0).
//  - backEndReady_o=fire; stallFrontEnd_o = |v && !fire && !flush_i. Empty bundle never stalls.
//  - dispValid_o=v&{W{fire}}; dispLoad_o=v&isLd&{W{fire}}; dispStore_o=v&isSt&{W{fire}}; dispPkt_o=pkt.
//  - fire is combinational from counts: counts must be registered by consumers (no same-cycle loop).
//  - A lane with both isLd and isSt is illegal; assertion flags it, LQ and SQ both charged.
//  - State machine: RUN --loadViolation_i--> DRAIN; DRAIN --fire--> RUN (one bundle released with
//    AL empty). loadViolation_i in DRAIN is absorbed. flush_i does NOT leave DRAIN.
//  - Flush: priority over everything; same cycle fire=0, bundle valids cleared next edge, incoming
//    rename bundle discarded. Flush + loadViolation same cycle -> DRAIN entered, bundle cleared.
//  - laneActive_i change mid-stall: held valids re-masked each cycle (v <= v & laneActive_i while held).
//  - Reset mid-stall: bundle dropped, state RUN.
// CONFIGURATION
//  DISPATCH_PERF_MON_EN defined: adds outputs alStall_o, iqStall_o, lqStall_o, sqStall_o, drainStall_o
//    (1 bit each, high when that term blocks a valid bundle, not under flush) and 32-bit saturating
//    stallCycles_o counting stallFrontEnd_o cycles; reset to 0.
//  Undefined: those ports and counter absent; functional behaviour identical.
// TESTING
//  1 Free flow: W=4, all counts 0, bundles of 4 valids each cycle -> dispValid_o=4'hF every cycle,
//    1-cycle latency, stallFrontEnd_o never 1.
//  2 Exact fill: alCnt_i=124, 4 valids -> fires; alCnt_i=125 -> stall, bundle held unchanged, fires
//    the cycle alCnt_i drops to 124.
//  3 LSQ limit: lqCnt_i=31, bundle with 2 loads, 0 stores -> stall (lqStall_o=1 with PERF); same bundle
//    with 1 load -> fires, dispLoad_o has one bit.
//  4 Drain: pulse loadViolation_i, next bundle held while alCnt_i=5; alCnt_i=0 -> fires, state RUN,
//    following bundle fires with alCnt_i=5.
//  5 Flush during stall: stalled bundle + flush_i=1 -> fire=0, stallFrontEnd_o=0, next cycle v=0.
//  6 Lane mask: laneActive_i=4'b0011, renValid_i=4'hF -> dispValid_o=4'b0011; drop to 4'b0001 while
//    stalled -> fires with 4'b0001.

Source files
------------

// File: rtl/dispatch_stage_param_if.sv
// rtl/dispatch_stage_param_if.sv - rename-side and dispatch-side bundle signals of the dispatch stage
interface dispatch_stage_param_if #(
    parameter int DISPATCH_WIDTH = 4,
    parameter int PKT_W          = 96
);
    logic                              renameReady_i;
    logic [DISPATCH_WIDTH-1:0]         renValid_i;
    logic [DISPATCH_WIDTH-1:0]         renIsLoad_i;
    logic [DISPATCH_WIDTH-1:0]         renIsStore_i;
    logic [DISPATCH_WIDTH*PKT_W-1:0]   renPkt_i;

    logic [DISPATCH_WIDTH-1:0]         dispValid_o;
    logic [DISPATCH_WIDTH-1:0]         dispLoad_o;
    logic [DISPATCH_WIDTH-1:0]         dispStore_o;
    logic [DISPATCH_WIDTH*PKT_W-1:0]   dispPkt_o;
    logic                              backEndReady_o;
    logic                              stallFrontEnd_o;

    modport master (
        output renameReady_i, renValid_i, renIsLoad_i, renIsStore_i, renPkt_i,
        input  dispValid_o, dispLoad_o, dispStore_o, dispPkt_o, backEndReady_o, stallFrontEnd_o
    );

    modport slave (
        input  renameReady_i, renValid_i, renIsLoad_i, renIsStore_i, renPkt_i,
        output dispValid_o, dispLoad_o, dispStore_o, dispPkt_o, backEndReady_o, stallFrontEnd_o
    );
endinterface

// File: rtl/dispatch_stage_param.sv
// rtl/dispatch_stage_param.sv - rename->dispatch bundle register with AL/IQ/LQ/SQ credit check and DRAIN mode
// Optional stall monitors and stall-cycle counter enabled by DISPATCH_PERF_MON_EN.
module dispatch_stage_param #(
    parameter int DISPATCH_WIDTH = 4,
    parameter int PKT_W          = 96,
    parameter int AL_SIZE        = 128,
    parameter int IQ_SIZE        = 64,
    parameter int LQ_SIZE        = 32,
    parameter int SQ_SIZE        = 32,
    parameter int CNT_W          = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [DISPATCH_WIDTH-1:0]  laneActive_i,
    input  logic                       flush_i,
    input  logic                       loadViolation_i,
    input  logic [CNT_W-1:0]           alCnt_i,
    input  logic [CNT_W-1:0]           iqCnt_i,
    input  logic [CNT_W-1:0]           lqCnt_i,
    input  logic [CNT_W-1:0]           sqCnt_i,
`ifdef DISPATCH_PERF_MON_EN
    output logic                       alStall_o,
    output logic                       iqStall_o,
    output logic                       lqStall_o,
    output logic                       sqStall_o,
    output logic                       drainStall_o,
    output logic [31:0]                stallCycles_o,
`endif
    dispatch_stage_param_if.slave      bus
);
    localparam int W = DISPATCH_WIDTH;

    typedef enum logic {RUN, DRAIN} state_e;

    state_e                state_q, state_d;
    logic [W-1:0]          v_q, v_d;
    logic [W-1:0]          ld_q, ld_d;
    logic [W-1:0]          st_q, st_d;
    logic [W*PKT_W-1:0]    pkt_q, pkt_d;

    function automatic logic [CNT_W:0] popcnt(input logic [W-1:0] x);
        logic [CNT_W:0] c;
        c = '0;
        for (int i = 0; i < W; i++) c = c + (CNT_W+1)'(x[i]);
        return c;
    endfunction

    // Sums carry one extra bit so a near-full count plus the bundle cannot wrap.
    logic [CNT_W:0] al_sum, iq_sum, lq_sum, sq_sum;
    logic           al_ok, iq_ok, lq_ok, sq_ok, drain_ok, any_v;
    logic           credit_ok, fire, stall;

    assign any_v  = |v_q;
    assign al_sum = {1'b0, alCnt_i} + popcnt(v_q);
    assign iq_sum = {1'b0, iqCnt_i} + popcnt(v_q);
    assign lq_sum = {1'b0, lqCnt_i} + popcnt(v_q & ld_q);
    assign sq_sum = {1'b0, sqCnt_i} + popcnt(v_q & st_q);
    assign al_ok  = al_sum <= (CNT_W+1)'(AL_SIZE);
    assign iq_ok  = iq_sum <= (CNT_W+1)'(IQ_SIZE);
    assign lq_ok  = lq_sum <= (CNT_W+1)'(LQ_SIZE);
    assign sq_ok  = sq_sum <= (CNT_W+1)'(SQ_SIZE);
    assign drain_ok  = (state_q == RUN) || (alCnt_i == '0);
    assign credit_ok = al_ok && iq_ok && lq_ok && sq_ok;
    assign fire      = any_v && credit_ok && !flush_i && drain_ok;
    assign stall     = any_v && !fire && !flush_i;

    assign bus.backEndReady_o  = fire;
    assign bus.stallFrontEnd_o = stall;
    assign bus.dispValid_o     = v_q & {W{fire}};
    assign bus.dispLoad_o      = v_q & ld_q & {W{fire}};
    assign bus.dispStore_o     = v_q & st_q & {W{fire}};
    assign bus.dispPkt_o       = pkt_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (loadViolation_i) state_d = DRAIN;
            DRAIN:   if (fire)            state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    // A held bundle keeps its payload but is re-masked by the current lane enables.
    always_comb begin
        v_d   = v_q;
        ld_d  = ld_q;
        st_d  = st_q;
        pkt_d = pkt_q;
        if (flush_i) begin
            v_d = '0;
        end else if (stall) begin
            v_d = v_q & laneActive_i;
        end else begin
            v_d   = bus.renameReady_i ? (bus.renValid_i & laneActive_i) : '0;
            ld_d  = bus.renIsLoad_i;
            st_d  = bus.renIsStore_i;
            pkt_d = bus.renPkt_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            v_q     <= '0;
            ld_q    <= '0;
            st_q    <= '0;
            pkt_q   <= '0;
        end else begin
            state_q <= state_d;
            v_q     <= v_d;
            ld_q    <= ld_d;
            st_q    <= st_d;
            pkt_q   <= pkt_d;
        end
    end

    // A lane flagged as both load and store is charged to LQ and SQ, but should never occur.
    assert property (@(posedge clk) disable iff (reset) (v_q & ld_q & st_q) == '0);

`ifdef DISPATCH_PERF_MON_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    assign alStall_o     = any_v && !flush_i && !al_ok;
    assign iqStall_o     = any_v && !flush_i && !iq_ok;
    assign lqStall_o     = any_v && !flush_i && !lq_ok;
    assign sqStall_o     = any_v && !flush_i && !sq_ok;
    assign drainStall_o  = any_v && !flush_i && !drain_ok;
    assign stallCycles_o = stall_cnt_q;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) stall_cnt_q <= '0;
        else       stall_cnt_q <= stall_cnt_d;
    end
`endif
endmodule
